l1d_evict_buffer: RTL



---
 rtl/l1d_evict_buffer_pkg.sv | 27 ++
 rtl/l1d_evict_buffer_entry.sv | 95 +++++++++
 rtl/l1d_evict_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/l1d_evict_buffer_pkg.sv
// rtl/l1d_evict_buffer_pkg.sv - shared types and sizes for the L1D dirty-victim evict buffer
package l1d_package;

   localparam int L1D_EVB_ENTRY_NUM  = 2;
   localparam int L1D_LINE_BEAT_NUM  = 4;
   localparam int L1D_BEAT_WIDTH     = 128;
   localparam int L1D_ADDR_WIDTH     = 40;
   localparam int L1D_MSHR_ID_WIDTH  = 3;

   // Index/counter width for n items, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int L1D_BEAT_IDX_WIDTH = cnt_width(L1D_LINE_BEAT_NUM);

   typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT_ACK} l1d_evb_state_e;

   typedef struct packed {
      logic [L1D_ADDR_WIDTH-1:0]     addr;
      logic [L1D_MSHR_ID_WIDTH-1:0]  mshr_id;
      logic [L1D_BEAT_IDX_WIDTH-1:0] beat_idx;
      logic [L1D_BEAT_WIDTH-1:0]     dat;
      logic                          last;
   } pack_l1d_wb_pld;

endpackage

// File: rtl/l1d_evict_buffer_entry.sv
// rtl/l1d_evict_buffer_entry.sv - one victim line buffer: state, owner id/addr, beats, beat counter
module l1d_evict_buffer_entry
   import l1d_package::*;
#(
   parameter int BEAT_NUM      = L1D_LINE_BEAT_NUM,
   parameter int DATA_WIDTH    = L1D_BEAT_WIDTH,
   parameter int ADDR_WIDTH    = L1D_ADDR_WIDTH,
   parameter int MSHR_ID_WIDTH = L1D_MSHR_ID_WIDTH,
   localparam int CNTW         = cnt_width(BEAT_NUM)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_en,
   input  logic [MSHR_ID_WIDTH-1:0] alloc_id,
   input  logic [ADDR_WIDTH-1:0]    alloc_addr,
   input  logic                     fill_en,
   input  logic [DATA_WIDTH-1:0]    fill_dat,
   input  logic                     send_en,
   input  logic                     ack_en,
   output l1d_evb_state_e           state_o,
   output logic [MSHR_ID_WIDTH-1:0] id_o,
   output logic [ADDR_WIDTH-1:0]    addr_o,
   output logic [CNTW-1:0]          cnt_o,
   output logic [DATA_WIDTH-1:0]    rd_dat_o,
   output logic                     last_beat_o
);

   l1d_evb_state_e           state_q, state_d;
   logic [MSHR_ID_WIDTH-1:0] id_q, id_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [CNTW-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]    beats_q [BEAT_NUM];
   logic [DATA_WIDTH-1:0]    beats_d [BEAT_NUM];
   logic                     at_last;

   assign at_last = (cnt_q == CNTW'(BEAT_NUM - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (alloc_en)            state_d = FILL;
         FILL:     if (fill_en && at_last)  state_d = SEND;
         SEND:     if (send_en && at_last)  state_d = WAIT_ACK;
         WAIT_ACK: if (ack_en)              state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   always_comb begin
      state_o     = state_q;
      id_o        = id_q;
      addr_o      = addr_q;
      cnt_o       = cnt_q;
      rd_dat_o    = beats_q[cnt_q];
      last_beat_o = at_last;
   end

   // One counter serves both phases: it wraps to 0 at the end of the fill and re-counts the send.
   always_comb begin
      id_d    = id_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      beats_d = beats_q;
      if (alloc_en) begin
         id_d   = alloc_id;
         addr_d = alloc_addr;
         cnt_d  = '0;
      end else if (fill_en || send_en) begin
         cnt_d = at_last ? '0 : cnt_q + 1'b1;
      end
      if (fill_en) beats_d[cnt_q] = fill_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_q   <= '0;
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         id_q   <= id_d;
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      beats_q <= beats_d;
   end

endmodule

// File: rtl/l1d_evict_buffer.sv
// rtl/l1d_evict_buffer.sv - dirty-victim evict buffer: allocator, order FIFO, id matching, pulses
module l1d_evict_buffer
   import l1d_package::*;
#(
   parameter int EVB_ENTRY_NUM = L1D_EVB_ENTRY_NUM,
   parameter int BEAT_NUM      = L1D_LINE_BEAT_NUM,
   parameter int DATA_WIDTH    = L1D_BEAT_WIDTH,
   parameter int ADDR_WIDTH    = L1D_ADDR_WIDTH,
   parameter int MSHR_ID_WIDTH = L1D_MSHR_ID_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     evict_start_vld,
   output logic                     evict_start_rdy,
   input  logic [MSHR_ID_WIDTH-1:0] evict_start_id,
   input  logic [ADDR_WIDTH-1:0]    evict_start_addr,
   input  logic                     ram_rd_vld,
   input  logic [MSHR_ID_WIDTH-1:0] ram_rd_id,
   input  logic [DATA_WIDTH-1:0]    ram_rd_dat,
   output logic                     evict_dat_ram_clean_en,
   output logic [MSHR_ID_WIDTH-1:0] evict_dat_ram_clean_id,
   output logic                     wb_vld,
   input  logic                     wb_rdy,
   output pack_l1d_wb_pld           wb_pld,
   input  logic                     wb_ack_vld,
   input  logic [MSHR_ID_WIDTH-1:0] wb_ack_id,
   output logic                     evict_done_en,
   output logic [MSHR_ID_WIDTH-1:0] evict_done_id
);

   localparam int IDXW = cnt_width(EVB_ENTRY_NUM);
   localparam int CNTW = cnt_width(BEAT_NUM);

   l1d_evb_state_e           ent_state [EVB_ENTRY_NUM];
   logic [MSHR_ID_WIDTH-1:0] ent_id    [EVB_ENTRY_NUM];
   logic [ADDR_WIDTH-1:0]    ent_addr  [EVB_ENTRY_NUM];
   logic [CNTW-1:0]          ent_cnt   [EVB_ENTRY_NUM];
   logic [DATA_WIDTH-1:0]    ent_dat   [EVB_ENTRY_NUM];
   logic [EVB_ENTRY_NUM-1:0] ent_last;
   logic [EVB_ENTRY_NUM-1:0] alloc_en, fill_en, send_en, ack_en;

   logic [IDXW-1:0] order_q [EVB_ENTRY_NUM];
   logic [IDXW-1:0] order_d [EVB_ENTRY_NUM];
   logic [IDXW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head_idx, alloc_idx;
   logic [IDXW:0]   fifo_cnt_q, fifo_cnt_d;
   logic            alloc_found, alloc_fire, wb_fire, fifo_pop, id_live;
   logic                     clean_en_q, clean_en_d, done_en_q, done_en_d;
   logic [MSHR_ID_WIDTH-1:0] clean_id_q, clean_id_d, done_id_q, done_id_d;

   for (genvar g = 0; g < EVB_ENTRY_NUM; g++) begin : g_ent
      l1d_evict_buffer_entry #(
         .BEAT_NUM      (BEAT_NUM),
         .DATA_WIDTH    (DATA_WIDTH),
         .ADDR_WIDTH    (ADDR_WIDTH),
         .MSHR_ID_WIDTH (MSHR_ID_WIDTH)
      ) u_entry (
         .clk         (clk),
         .rst_n       (rst_n),
         .alloc_en    (alloc_en[g]),
         .alloc_id    (evict_start_id),
         .alloc_addr  (evict_start_addr),
         .fill_en     (fill_en[g]),
         .fill_dat    (ram_rd_dat),
         .send_en     (send_en[g]),
         .ack_en      (ack_en[g]),
         .state_o     (ent_state[g]),
         .id_o        (ent_id[g]),
         .addr_o      (ent_addr[g]),
         .cnt_o       (ent_cnt[g]),
         .rd_dat_o    (ent_dat[g]),
         .last_beat_o (ent_last[g])
      );
   end

   function automatic logic [IDXW-1:0] ptr_inc(input logic [IDXW-1:0] p);
      return (p == IDXW'(EVB_ENTRY_NUM - 1)) ? '0 : p + 1'b1;
   endfunction

   // Only the oldest allocated line may drive the bus, and only once fully captured.
   always_comb begin
      head_idx = order_q[rd_ptr_q];
      wb_vld   = (fifo_cnt_q != '0) && (ent_state[head_idx] == SEND);
      wb_fire  = wb_vld && wb_rdy;
      fifo_pop = wb_fire && ent_last[head_idx];
      wb_pld   = '0;
      if (wb_vld) begin
         wb_pld.addr     = ent_addr[head_idx];
         wb_pld.mshr_id  = ent_id[head_idx];
         wb_pld.beat_idx = ent_cnt[head_idx];
         wb_pld.dat      = ent_dat[head_idx];
         wb_pld.last     = ent_last[head_idx];
      end
   end

   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      id_live     = 1'b0;
      for (int i = 0; i < EVB_ENTRY_NUM; i++) begin
         if (!alloc_found && ent_state[i] == IDLE) begin
            alloc_found = 1'b1;
            alloc_idx   = IDXW'(i);
         end
         if (ent_state[i] != IDLE && ent_id[i] == evict_start_id) id_live = 1'b1;
      end
      evict_start_rdy = alloc_found;
      alloc_fire      = evict_start_vld && alloc_found;
      for (int i = 0; i < EVB_ENTRY_NUM; i++) begin
         alloc_en[i] = alloc_fire && (alloc_idx == IDXW'(i));
         fill_en[i]  = ram_rd_vld && (ent_state[i] == FILL) && (ent_id[i] == ram_rd_id);
         ack_en[i]   = wb_ack_vld && (ent_state[i] == WAIT_ACK) && (ent_id[i] == wb_ack_id);
         send_en[i]  = wb_fire && (head_idx == IDXW'(i));
      end
   end

   always_comb begin
      order_d    = order_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + {{IDXW{1'b0}}, alloc_fire} - {{IDXW{1'b0}}, fifo_pop};
      if (alloc_fire) begin
         order_d[wr_ptr_q] = alloc_idx;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      clean_en_d = |(fill_en & ent_last);
      clean_id_d = clean_en_d ? ram_rd_id : '0;
      done_en_d  = |ack_en;
      done_id_d  = done_en_d ? wb_ack_id : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         order_q    <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         clean_en_q <= 1'b0;
         clean_id_q <= '0;
         done_en_q  <= 1'b0;
         done_id_q  <= '0;
      end else begin
         order_q    <= order_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         clean_en_q <= clean_en_d;
         clean_id_q <= clean_id_d;
         done_en_q  <= done_en_d;
         done_id_q  <= done_id_d;
      end
   end

   assign evict_dat_ram_clean_en = clean_en_q;
   assign evict_dat_ram_clean_id = clean_id_q;
   assign evict_done_en          = done_en_q;
   assign evict_done_id          = done_id_q;

   a_fill_has_owner: assert property (@(posedge clk) disable iff (!rst_n) ram_rd_vld |-> |fill_en);
   a_ack_has_owner:  assert property (@(posedge clk) disable iff (!rst_n) wb_ack_vld |-> |ack_en);
   a_id_unique:      assert property (@(posedge clk) disable iff (!rst_n) alloc_fire |-> !id_live);

endmodule
